// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch constants and fetch FSM state encoding
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // ADDI x0,x0,0 used as the decode bubble
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

  // Fetch FSM encoding
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HELD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/if_id_stage_if.sv
// rtl/if_id_stage_if.sv - instruction memory request/ack bus
interface if_id_stage_if;
  import riscv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  // Fetch stage side
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  // Instruction memory side
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/pc_next_gen.sv
// rtl/pc_next_gen.sv - next fetch address select: redirect target, pc+4 or hold
module pc_next_gen
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  output logic [XLEN-1:0] pc_next
);

  // Redirect target is forced word-aligned; pc+4 wraps modulo 2^32
  always_comb begin
    pc_next = pc;
    if (redirect) begin
      pc_next = redirect_pc & ~XLEN'(3);
    end else if (advance) begin
      pc_next = pc + XLEN'(4);
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - instruction fetch FSM, hold buffer and IF/ID pipeline register
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  if_id_stage_if.master         imem,
  output logic [31:0]           pc_if_id,
  output logic [31:0]           instr_if_id,
  output logic                  valid_if_id
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_if_id_q, pc_if_id_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        advance;

  // The request is only visible in FETCH and is suppressed while reset is held
  assign imem.imem_req  = (state_q == riscv_pkg::ST_FETCH) && !reset;
  assign imem.imem_addr = reset ? RESET_PC : pc_q;

  assign pc_if_id    = pc_if_id_q;
  assign instr_if_id = instr_q;
  assign valid_if_id = valid_q;

  pc_next_gen u_pc_next_gen (
    .pc          (pc_q),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .advance     (advance),
    .pc_next     (pc_d)
  );

  // Next-state: redirect beats stall, stall beats normal fetch
  always_comb begin
    state_d      = state_q;
    advance      = 1'b0;
    pc_if_id_d   = pc_if_id_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    if (redirect) begin
      instr_d      = NOP_INSTR;
      valid_d      = 1'b0;
      hold_instr_d = '0;
      hold_pc_d    = '0;
      // An unacked request in FETCH or DRAIN is still in flight and must be drained
      if ((state_q != riscv_pkg::ST_HELD) && !imem.imem_ack) begin
        state_d = riscv_pkg::ST_DRAIN;
      end else begin
        state_d = riscv_pkg::ST_FETCH;
      end
    end else begin
      case (state_q)
        riscv_pkg::ST_FETCH: begin
          if (imem.imem_ack) begin
            if (stall) begin
              hold_instr_d = imem.imem_rdata;
              hold_pc_d    = pc_q;
              state_d      = riscv_pkg::ST_HELD;
            end else begin
              pc_if_id_d = pc_q;
              instr_d    = imem.imem_rdata;
              valid_d    = 1'b1;
              advance    = 1'b1;
            end
          end else if (!stall) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end
        end
        riscv_pkg::ST_HELD: begin
          if (!stall) begin
            pc_if_id_d = hold_pc_q;
            instr_d    = hold_instr_q;
            valid_d    = 1'b1;
            advance    = 1'b1;
            state_d    = riscv_pkg::ST_FETCH;
          end
        end
        riscv_pkg::ST_DRAIN: begin
          // Stale data is dropped; IF/ID keeps the bubble left by the redirect
          if (imem.imem_ack) begin
            state_d = riscv_pkg::ST_FETCH;
          end
        end
        default: state_d = riscv_pkg::ST_FETCH;
      endcase
    end
  end

  // State registers with synchronous reset; reset drops any outstanding request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= riscv_pkg::ST_FETCH;
      pc_q         <= RESET_PC;
      pc_if_id_q   <= '0;
      instr_q      <= NOP_INSTR;
      valid_q      <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_if_id_q   <= pc_if_id_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed self-checking bench for if_id_stage
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_if_id;
  logic [31:0] instr_if_id;
  logic        valid_if_id;

  int n_cmp;
  int n_err;

  if_id_stage_if imem_bus ();

  if_id_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem_bus),
    .pc_if_id    (pc_if_id),
    .instr_if_id (instr_if_id),
    .valid_if_id (valid_if_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                          input logic valid);
    chk({tag, ".pc"}, pc_if_id, pc);
    chk({tag, ".instr"}, instr_if_id, instr);
    chk({tag, ".valid"}, {31'b0, valid_if_id}, {31'b0, valid});
  endtask

  task automatic chk_bus(input string tag, input logic req, input logic [31:0] addr);
    #1;
    chk({tag, ".req"}, {31'b0, imem_bus.imem_req}, {31'b0, req});
    chk({tag, ".addr"}, imem_bus.imem_addr, addr);
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic ack, input logic [31:0] rdata);
    stall               = st;
    redirect            = rd;
    redirect_pc         = rpc;
    imem_bus.imem_ack   = ack;
    imem_bus.imem_rdata = rdata;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Reset with a stray ack that must be ignored
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    tick();
    tick();
    chk_bus("rst", 1'b0, 32'h0);
    chk_ifid("rst", 32'h0, NOP, 1'b0);

    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_bus("first", 1'b1, 32'h0);

    // Same-cycle acks on consecutive cycles
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0050_0093);
    tick();
    chk_ifid("f0", 32'h0, 32'h0050_0093, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h00A0_0113);
    chk_bus("f1", 1'b1, 32'h4);
    tick();
    chk_ifid("f1", 32'h4, 32'h00A0_0113, 1'b1);

    // Three-cycle ack latency: address stable, bubbles meanwhile
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_bus("lat", 1'b1, 32'h8);
      tick();
      chk_ifid("lat", 32'h4, NOP, 1'b0);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h1111_1111);
    tick();
    chk_ifid("lat_done", 32'h8, 32'h1111_1111, 1'b1);

    // Ack under stall goes to the hold buffer
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_A183);
    chk_bus("stl_ack", 1'b1, 32'hC);
    tick();
    chk_ifid("stl1", 32'h8, 32'h1111_1111, 1'b1);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_bus("held", 1'b0, 32'hC);
      tick();
      chk_ifid("held", 32'h8, 32'h1111_1111, 1'b1);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk_ifid("release", 32'hC, 32'h0000_A183, 1'b1);
    chk_bus("release", 1'b1, 32'h10);
    tick();
    chk_ifid("nodup", 32'hC, NOP, 1'b0);

    // Stall without ack: everything holds, request stays up
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk_ifid("stl_noack", 32'hC, NOP, 1'b0);
    chk_bus("stl_noack", 1'b1, 32'h10);

    // Redirect with request outstanding -> drain stale ack
    drive(1'b0, 1'b1, 32'h0000_0103, 1'b0, 32'h0);
    tick();
    chk_ifid("redir", 32'hC, NOP, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_bus("drain", 1'b0, 32'h100);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hBADB_AD00);
    chk_bus("drain_ack", 1'b0, 32'h100);
    tick();
    chk_ifid("stale", 32'hC, NOP, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h2222_2222);
    chk_bus("refetch", 1'b1, 32'h100);
    tick();
    chk_ifid("refetch", 32'h100, 32'h2222_2222, 1'b1);

    // Redirect and stall together (with an ack): redirect wins
    drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h3333_3333);
    tick();
    chk_ifid("rd_stl", 32'h100, NOP, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h4444_4444);
    chk_bus("rd_stl", 1'b1, 32'hFFFF_FFFC);

    // PC wrap
    tick();
    chk_ifid("wrap", 32'hFFFF_FFFC, 32'h4444_4444, 1'b1);
    chk_bus("wrap", 1'b1, 32'h0);

    // Reset mid-request
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h5555_5555);
    chk_bus("rst2", 1'b0, 32'h0);
    tick();
    chk_ifid("rst2", 32'h0, NOP, 1'b0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_bus("rst2_rel", 1'b1, 32'h0);
    tick();
    chk_ifid("rst2_rel", 32'h0, NOP, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
